// File: rtl/cone_eval_sched.sv
// -----------------------------------------------------------------------------
// cone_eval_sched
//
// Round-robin scheduler that time-shares one combinational evaluation cone
// among NUM_REQ requesters. One 5-bit operand is accepted at a time. It is
// driven onto cone_x and held for SETTLE cycles. cone_y is then sampled and
// returned as rsp_y, tagged with the requester index in rsp_id. The response
// is held until rsp_ready.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   req_valid  in   [NUM_REQ]    per-requester operand valid
//   req_data   in   [5*NUM_REQ]  operands, requester i on bits [5i+4:5i]
//   req_ready  out  [NUM_REQ]    one-hot accept strobe (IDLE only)
//   cone_x     out  [5]          registered drive to the shared cone
//   cone_y     in                shared cone output (combinational of cone_x)
//   rsp_valid  out               result valid
//   rsp_id     out  [ID_W]       requester index of the result
//   rsp_y      out               sampled cone result
//   rsp_ready  in                result consumer ready
//   busy       out               high whenever not IDLE
// -----------------------------------------------------------------------------
module cone_eval_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int SETTLE  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [5*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [4:0]           cone_x,
    input  logic                 cone_y,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_y,
    input  logic                 rsp_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SETTLE_ST = 2'd1,
        HOLD      = 2'd2
    } state_t;

    localparam logic [ID_W:0]   NREQ_W    = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);
    localparam logic [3:0]      SETTLE_M1 = 4'(SETTLE - 1);

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic [ID_W-1:0] last_q;
    logic [4:0]      cone_x_q;
    logic [ID_W-1:0] rsp_id_q;
    logic            rsp_y_q;
    logic            rsp_valid_q;
    logic            busy_q;

    // Per-requester view of the packed operand bus.
    logic [4:0] operand [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign operand[gi] = req_data[5*gi +: 5];
        end
    endgenerate

    // Round-robin search starting just after the last grant. The loop runs
    // from the farthest candidate to the nearest so that the nearest valid
    // requester is the final (winning) assignment.
    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, last_q} + (ID_W+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    // The accept strobe is combinational so the handshake completes on the
    // same edge that loads the operand. It is masked during reset because
    // no accept can happen while reset is held.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found && !rst) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= LAST_INIT;
            cone_x_q    <= '0;
            rsp_id_q    <= '0;
            rsp_y_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        cone_x_q <= operand[grant_idx];
                        rsp_id_q <= grant_idx;
                        last_q   <= grant_idx;
                        cnt_q    <= SETTLE_M1;
                        busy_q   <= 1'b1;
                        state_q  <= SETTLE_ST;
                    end
                end
                SETTLE_ST: begin
                    if (cnt_q == '0) begin
                        rsp_y_q     <= cone_y;
                        rsp_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                HOLD: begin
                    // cone_x is left untouched. It changes only on the
                    // next accept.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cone_x    = cone_x_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cone_eval_sched.sv
// -----------------------------------------------------------------------------
// Bench for cone_eval_sched (NUM_REQ=4, SETTLE=4). The shared cone netlist is
// modelled as a continuous assignment on cone_x. Expected grants come from a
// modulo round-robin search over the current valid set. Expected results come
// from the cone equation.
// -----------------------------------------------------------------------------
module tb_cone_eval_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int SETTLE  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [5*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4:0]           cone_x;
    logic                 cone_y;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_y;
    logic                 rsp_ready;
    logic                 busy;

    always #5 clk = ~clk;

    // Shared cone netlist seen by the scheduler.
    assign cone_y = !(cone_x[0] && cone_x[1] && cone_x[2]) && !(cone_x[4] && !cone_x[3]);

    cone_eval_sched #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .cone_x   (cone_x),
        .cone_y   (cone_y),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_y    (rsp_y),
        .rsp_ready(rsp_ready),
        .busy     (busy)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int ref_last;

    logic [NUM_REQ-1:0] rv;
    logic [4:0]         rd [NUM_REQ];

    // ---------------- reference model ----------------
    function automatic logic model_y(input logic [4:0] x);
        return ~((x[0] & x[1] & x[2]) | (x[4] & ~x[3]));
    endfunction

    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        if (v == '0) return -1;
        if ($countones(v) != 1) return -2;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -2;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic drive();
        req_valid = rv;
        for (int i = 0; i < NUM_REQ; i++) req_data[5*i +: 5] = rd[i];
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rv  = '0;
        drive();
        tick();
        tick();
        rst = 1'b0;
        #1;
        ref_last = NUM_REQ - 1;
    endtask

    task automatic await_grant(output int g, output int waited);
        waited = 0;
        g = onehot_idx(req_ready);
        while (g == -1 && waited < 40) begin
            tick();
            waited++;
            g = onehot_idx(req_ready);
        end
    endtask

    task automatic await_rsp(output int waited);
        waited = 0;
        while (!rsp_valid && waited < 40) begin
            tick();
            waited++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b0;
        rv        = '1;
        for (int i = 0; i < NUM_REQ; i++) rd[i] = 5'($urandom);
        drive();
        tick();
        checks++;
        if (req_ready !== 4'b0000) $display("FAIL reset_no_grant: req_ready=%b want 0000", req_ready);
        else passes++;
        rv = '0;
        drive();
        tick();
        rst = 1'b0;
        #1;
        ref_last = NUM_REQ - 1;
        checks++;
        if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else passes++;
        checks++;
        if (cone_x !== 5'b00000) $display("FAIL reset_cone_x: got %b want 00000", cone_x); else passes++;
        checks++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passes++;
        checks++;
        if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); else passes++;
        checks++;
        if (rsp_y !== 1'b0) $display("FAIL reset_rsp_y: got %b want 0", rsp_y); else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        $display("reset: outputs idle");
    endtask

    task automatic test_basic();
        int w;
        rsp_ready = 1'b1;
        rv        = 4'b0001;
        rd[0]     = 5'b00111;
        drive();
        checks++;
        if (req_ready !== 4'b0001) $display("FAIL basic_ready: got %b want 0001", req_ready); else passes++;
        tick();
        rv = '0;
        drive();
        ref_last = 0;
        checks++;
        if (req_ready !== 4'b0000) $display("FAIL basic_ready_drop: got %b want 0000", req_ready); else passes++;
        checks++;
        if (cone_x !== 5'b00111) $display("FAIL basic_cone_x: got %b want 00111", cone_x); else passes++;
        checks++;
        if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passes++;
        await_rsp(w);
        checks++;
        if (w != SETTLE) $display("FAIL basic_latency: got %0d want %0d", w, SETTLE); else passes++;
        checks++;
        if (rsp_id !== 2'd0 || rsp_y !== model_y(5'b00111))
            $display("FAIL basic_rsp: got id=%0d y=%b want id=0 y=%b", rsp_id, rsp_y, model_y(5'b00111));
        else passes++;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || cone_x !== 5'b00111)
            $display("FAIL basic_after: got valid=%b busy=%b x=%b want 0 0 00111", rsp_valid, busy, cone_x);
        else passes++;
        $display("basic: id=%0d y=%b latency=%0d", rsp_id, rsp_y, w);
    endtask

    task automatic test_single_req2();
        logic [4:0] ops [3];
        int g, w, prev_c;
        ops = '{5'b10000, 5'b11000, 5'b00000};
        rsp_ready = 1'b1;
        rv        = 4'b0100;
        rd[2]     = ops[0];
        drive();
        prev_c = -1;
        for (int n = 0; n < 3; n++) begin
            await_grant(g, w);
            checks++;
            if (g != 2) $display("FAIL single_grant%0d: got %0d want 2", n, g); else passes++;
            if (n > 0) begin
                checks++;
                if (cyc - prev_c != SETTLE + 2)
                    $display("FAIL single_spacing%0d: got %0d want %0d", n, cyc - prev_c, SETTLE + 2);
                else passes++;
            end
            prev_c = cyc;
            tick();
            if (n < 2) rd[2] = ops[n+1];
            else       rv = '0;
            drive();
            checks++;
            if (cone_x !== ops[n]) $display("FAIL single_cone_x%0d: got %b want %b", n, cone_x, ops[n]); else passes++;
            await_rsp(w);
            checks++;
            if (w != SETTLE || rsp_id !== 2'd2 || rsp_y !== model_y(ops[n]))
                $display("FAIL single_rsp%0d: got lat=%0d id=%0d y=%b want lat=%0d id=2 y=%b",
                         n, w, rsp_id, rsp_y, SETTLE, model_y(ops[n]));
            else passes++;
            $display("single: op=%b id=%0d y=%b", ops[n], rsp_id, rsp_y);
            tick();
        end
        ref_last = 2;
    endtask

    task automatic test_round_robin();
        int g, w, exp;
        logic [4:0] old;
        do_reset();
        rsp_ready = 1'b1;
        rv        = '1;
        for (int i = 0; i < NUM_REQ; i++) rd[i] = 5'($urandom);
        drive();
        for (int n = 0; n < 8; n++) begin
            exp = model_pick(rv, ref_last);
            await_grant(g, w);
            checks++;
            if (g != exp) $display("FAIL rr_grant%0d: got %0d want %0d", n, g, exp); else passes++;
            if (n > 0) begin
                checks++;
                if (busy !== 1'b0 || w != 0)
                    $display("FAIL rr_idle_gap%0d: got busy=%b extra_wait=%0d want busy=0 wait=0", n, busy, w);
                else passes++;
            end
            tick();
            old      = rd[exp < 0 ? 0 : exp];
            ref_last = exp;
            if (exp >= 0) rd[exp] = 5'($urandom);
            drive();
            checks++;
            if (busy !== 1'b1 || cone_x !== old)
                $display("FAIL rr_accept%0d: got busy=%b x=%b want busy=1 x=%b", n, busy, cone_x, old);
            else passes++;
            await_rsp(w);
            checks++;
            if (rsp_id !== ID_W'(exp) || rsp_y !== model_y(old))
                $display("FAIL rr_rsp%0d: got id=%0d y=%b want id=%0d y=%b", n, rsp_id, rsp_y, exp, model_y(old));
            else passes++;
            $display("rr: grant=%0d id=%0d y=%b", g, rsp_id, rsp_y);
            tick();
        end
        rv = '0;
        drive();
    endtask

    task automatic test_backpressure();
        int g, w, exp;
        logic [4:0] old;
        logic stable_ok, quiet_ok;
        rsp_ready = 1'b0;
        rv        = 4'b0110;
        rd[1]     = 5'($urandom);
        rd[2]     = 5'($urandom);
        drive();
        exp = model_pick(rv, ref_last);
        await_grant(g, w);
        checks++;
        if (g != exp) $display("FAIL bp_grant: got %0d want %0d", g, exp); else passes++;
        tick();
        ref_last = exp;
        old      = rd[exp < 0 ? 0 : exp];
        await_rsp(w);
        checks++;
        if (w != SETTLE) $display("FAIL bp_latency: got %0d want %0d", w, SETTLE); else passes++;
        stable_ok = 1'b1;
        quiet_ok  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(exp) || rsp_y !== model_y(old) || cone_x !== old)
                stable_ok = 1'b0;
            if (req_ready !== 4'b0000 || busy !== 1'b1) quiet_ok = 1'b0;
        end
        checks++;
        if (stable_ok !== 1'b1)
            $display("FAIL bp_hold_stable: got valid=%b id=%0d y=%b x=%b want 1 %0d %b %b",
                     rsp_valid, rsp_id, rsp_y, cone_x, exp, model_y(old), old);
        else passes++;
        checks++;
        if (quiet_ok !== 1'b1) $display("FAIL bp_no_grant: got req_ready=%b busy=%b want 0000 1", req_ready, busy);
        else passes++;
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL bp_release: got valid=%b busy=%b want 0 0", rsp_valid, busy);
        else passes++;
        checks++;
        if (onehot_idx(req_ready) != model_pick(rv, ref_last))
            $display("FAIL bp_next_grant: got %b want idx %0d", req_ready, model_pick(rv, ref_last));
        else passes++;
        $display("backpressure: held id=%0d y=%b for 10 cycles", exp, model_y(old));
        rv = '0;
        drive();
    endtask

    task automatic test_reset_mid();
        int g, w;
        logic no_rsp;
        do_reset();
        rsp_ready = 1'b1;
        rv        = 4'b0010;
        rd[1]     = 5'($urandom);
        drive();
        await_grant(g, w);
        checks++;
        if (g != 1) $display("FAIL rmid_first_grant: got %0d want 1", g); else passes++;
        tick();
        rv = '0;
        drive();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || cone_x !== 5'b0 || rsp_valid !== 1'b0 ||
            rsp_id !== 2'd0 || rsp_y !== 1'b0 || busy !== 1'b0)
            $display("FAIL rmid_reset_vals: got rdy=%b x=%b v=%b id=%0d y=%b busy=%b want all 0",
                     req_ready, cone_x, rsp_valid, rsp_id, rsp_y, busy);
        else passes++;
        tick();
        rst = 1'b0;
        #1;
        ref_last = NUM_REQ - 1;
        no_rsp   = 1'b1;
        for (int c = 0; c < SETTLE + 3; c++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) no_rsp = 1'b0;
        end
        checks++;
        if (no_rsp !== 1'b1) $display("FAIL rmid_abandoned: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
        else passes++;
        rv    = 4'b1010;
        rd[1] = 5'($urandom);
        rd[3] = 5'($urandom);
        drive();
        checks++;
        if (onehot_idx(req_ready) != model_pick(rv, ref_last))
            $display("FAIL rmid_next_grant: got %b want idx %0d", req_ready, model_pick(rv, ref_last));
        else passes++;
        $display("reset_mid: next grant idx=%0d", onehot_idx(req_ready));
        rv = '0;
        drive();
    endtask

    task automatic test_skip_wrap();
        int g, w;
        int exp_g [4];
        logic [NUM_REQ-1:0] masks [4];
        logic [4:0] old;
        exp_g = '{1, 3, 0, 2};
        masks = '{4'b1010, 4'b0101, 4'b0100, 4'b0000};
        do_reset();
        rsp_ready = 1'b1;
        rv        = 4'b1010;
        for (int i = 0; i < NUM_REQ; i++) rd[i] = 5'($urandom);
        drive();
        for (int n = 0; n < 4; n++) begin
            await_grant(g, w);
            checks++;
            if (g != exp_g[n]) $display("FAIL skip_grant%0d: got %0d want %0d", n, g, exp_g[n]); else passes++;
            tick();
            old            = rd[exp_g[n]];
            rd[exp_g[n]]   = 5'($urandom);
            rv             = masks[n];
            drive();
            await_rsp(w);
            checks++;
            if (rsp_id !== ID_W'(exp_g[n]) || rsp_y !== model_y(old))
                $display("FAIL skip_rsp%0d: got id=%0d y=%b want id=%0d y=%b",
                         n, rsp_id, rsp_y, exp_g[n], model_y(old));
            else passes++;
            $display("skip_wrap: grant=%0d id=%0d y=%b", g, rsp_id, rsp_y);
            tick();
        end
        ref_last = 2;
    endtask

    task automatic test_random();
        int g, w, exp, hold;
        logic [4:0] old;
        do_reset();
        rv = '0;
        for (int i = 0; i < NUM_REQ; i++) rd[i] = 5'($urandom);
        for (int n = 0; n < 30; n++) begin
            if (rv == '0) rv = NUM_REQ'($urandom_range(1, 15));
            drive();
            exp = model_pick(rv, ref_last);
            await_grant(g, w);
            checks++;
            if (g != exp) $display("FAIL rnd_grant%0d: got %0d want %0d (valid=%b)", n, g, exp, rv); else passes++;
            hold      = $urandom_range(0, 3);
            rsp_ready = (hold == 0);
            tick();
            ref_last = exp;
            old      = rd[exp < 0 ? 0 : exp];
            if (exp >= 0) begin
                rv[exp] = 1'($urandom_range(0, 1));
                rd[exp] = 5'($urandom);
            end
            rv = rv | NUM_REQ'($urandom);
            drive();
            checks++;
            if (cone_x !== old) $display("FAIL rnd_cone_x%0d: got %b want %b", n, cone_x, old); else passes++;
            await_rsp(w);
            checks++;
            if (w != SETTLE || rsp_id !== ID_W'(exp) || rsp_y !== model_y(old))
                $display("FAIL rnd_rsp%0d: got lat=%0d id=%0d y=%b want lat=%0d id=%0d y=%b",
                         n, w, rsp_id, rsp_y, SETTLE, exp, model_y(old));
            else passes++;
            $display("random: n=%0d grant=%0d x=%b y=%b hold=%0d", n, g, old, rsp_y, hold);
            for (int h = 0; h < hold; h++) tick();
            checks++;
            if (rsp_valid !== 1'b1) $display("FAIL rnd_held%0d: got rsp_valid=%b want 1", n, rsp_valid); else passes++;
            rsp_ready = 1'b1;
            tick();
            checks++;
            if (rsp_valid !== 1'b0) $display("FAIL rnd_consumed%0d: got rsp_valid=%b want 0", n, rsp_valid); else passes++;
        end
        rv = '0;
        drive();
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rv        = '0;
        for (int i = 0; i < NUM_REQ; i++) rd[i] = '0;
        test_reset();
        test_basic();
        test_single_req2();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_skip_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

endmodule
